// File: rtl/mult_result_display.sv
// Captures a 16-bit multiplier product on each done_flag rising edge, converts it to five
// BCD digits with a bit-serial double-dabble engine, and scans it onto a 7-segment display.
module mult_result_display #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        done_flag,
    input  logic [15:0] d_in,
    input  logic        ovr_clr,
    output logic        busy,
    output logic        bcd_valid,
    output logic [19:0] bcd_out,
    output logic        overrun,
    output logic [7:0]  seg_an,
    output logic [6:0]  seg_data
);

    localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {StIdle, StShift, StLatch} state_e;

    state_e          state_q;
    logic            done_q;
    logic            start;
    logic [15:0]     bin_sr_q;
    logic [19:0]     bcd_sr_q;
    logic [19:0]     bcd_adj;
    logic [3:0]      bitcnt_q;
    logic [CntW-1:0] cnt_q;
    logic [2:0]      idx_q;
    logic [3:0]      digit;
    logic            lit;

    always_comb begin
        start = done_flag & ~done_q;
    end

    // Add-3 correction applied to every nibble before each shift.
    always_comb begin
        bcd_adj = bcd_sr_q;
        for (int i = 0; i < 5; i++) begin
            if (bcd_sr_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_sr_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            done_q    <= 1'b0;
            bin_sr_q  <= '0;
            bcd_sr_q  <= '0;
            bitcnt_q  <= '0;
            busy      <= 1'b0;
            bcd_valid <= 1'b0;
            bcd_out   <= '0;
            overrun   <= 1'b0;
        end else begin
            done_q    <= done_flag;
            bcd_valid <= 1'b0;

            // A new result arriving mid-conversion is dropped; setting beats clearing.
            if (start && (state_q != StIdle)) begin
                overrun <= 1'b1;
            end else if (ovr_clr) begin
                overrun <= 1'b0;
            end

            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        bin_sr_q <= d_in;
                        bcd_sr_q <= '0;
                        bitcnt_q <= '0;
                        busy     <= 1'b1;
                        state_q  <= StShift;
                    end
                end
                StShift: begin
                    {bcd_sr_q, bin_sr_q} <= {bcd_adj, bin_sr_q} << 1;
                    bitcnt_q             <= bitcnt_q + 4'd1;
                    if (bitcnt_q == 4'd15) begin
                        state_q <= StLatch;
                    end
                end
                StLatch: begin
                    bcd_out   <= bcd_sr_q;
                    bcd_valid <= 1'b1;
                    busy      <= 1'b0;
                    state_q   <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else if (cnt_q == CntW'(SCAN_DIV - 1)) begin
            cnt_q <= '0;
            idx_q <= (idx_q == 3'd4) ? 3'd0 : idx_q + 3'd1;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Leading-zero blanking: a digit is lit only if it or a more significant digit is non-zero.
    always_comb begin
        digit = 4'd0;
        lit   = 1'b0;
        case (idx_q)
            3'd0: begin digit = bcd_out[3:0];   lit = 1'b1;            end
            3'd1: begin digit = bcd_out[7:4];   lit = |bcd_out[19:4];  end
            3'd2: begin digit = bcd_out[11:8];  lit = |bcd_out[19:8];  end
            3'd3: begin digit = bcd_out[15:12]; lit = |bcd_out[19:12]; end
            3'd4: begin digit = bcd_out[19:16]; lit = |bcd_out[19:16]; end
            default: begin digit = 4'd0; lit = 1'b0; end
        endcase
    end

    always_comb begin
        seg_an   = ~(8'd1 << idx_q);
        seg_data = 7'h7F;
        if (lit) begin
            case (digit)
                4'd0:    seg_data = 7'b1000000;
                4'd1:    seg_data = 7'b1111001;
                4'd2:    seg_data = 7'b0100100;
                4'd3:    seg_data = 7'b0110000;
                4'd4:    seg_data = 7'b0011001;
                4'd5:    seg_data = 7'b0010010;
                4'd6:    seg_data = 7'b0000010;
                4'd7:    seg_data = 7'b1111000;
                4'd8:    seg_data = 7'b0000000;
                4'd9:    seg_data = 7'b0010000;
                default: seg_data = 7'h7F;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_result_display.sv
// Directed self-checking bench for mult_result_display with a short scan period.
module tb_mult_result_display;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        done_flag = 1'b0;
    logic [15:0] d_in = '0;
    logic        ovr_clr = 1'b0;
    logic        busy;
    logic        bcd_valid;
    logic [19:0] bcd_out;
    logic        overrun;
    logic [7:0]  seg_an;
    logic [6:0]  seg_data;

    int passed = 0;
    int total  = 0;

    mult_result_display #(.SCAN_DIV(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .done_flag (done_flag),
        .d_in      (d_in),
        .ovr_clr   (ovr_clr),
        .busy      (busy),
        .bcd_valid (bcd_valid),
        .bcd_out   (bcd_out),
        .overrun   (overrun),
        .seg_an    (seg_an),
        .seg_data  (seg_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    // Run one conversion from a clean done_flag edge and check latency and result.
    task automatic convert(input logic [15:0] val, input logic [19:0] exp_bcd, input string tag);
        int n;
        done_flag = 1'b0;
        d_in      = val;
        tick();
        done_flag = 1'b1;
        tick();
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (bcd_valid) begin
                n = i;
                break;
            end
        end
        chk({tag, "_latency"}, n, 17);
        chk({tag, "_bcd"}, {12'd0, bcd_out}, {12'd0, exp_bcd});
        chk({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
        tick();
        chk({tag, "_valid_1cyc"}, {31'd0, bcd_valid}, 32'd0);
        done_flag = 1'b0;
    endtask

    // Wait for digit slot k to be enabled, then check its segment pattern.
    task automatic show(input int k, input logic [6:0] exp_seg, input string tag);
        logic [7:0] exp_an;
        exp_an = ~(8'd1 << k);
        for (int i = 0; i < 40; i++) begin
            if (seg_an == exp_an) break;
            tick();
        end
        chk({tag, "_an"}, {24'd0, seg_an}, {24'd0, exp_an});
        chk({tag, "_seg"}, {25'd0, seg_data}, {25'd0, exp_seg});
    endtask

    initial begin
        int pulses;

        #1 rst = 1'b0;
        #2;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_valid", {31'd0, bcd_valid}, 32'd0);
        chk("rst_ovr", {31'd0, overrun}, 32'd0);
        chk("rst_bcd", {12'd0, bcd_out}, 32'd0);
        chk("rst_an", {24'd0, seg_an}, 32'hFE);
        chk("rst_seg", {25'd0, seg_data}, 32'h40);
        #19 rst = 1'b1;
        tick();

        // Full-scale product, every digit lit.
        convert(16'd65535, 20'h65535, "t2");
        show(0, 7'b0010010, "t2_d0");
        show(1, 7'b0110000, "t2_d1");
        show(2, 7'b0010010, "t2_d2");
        show(3, 7'b0010010, "t2_d3");
        show(4, 7'b0000010, "t2_d4");

        convert(16'd42, 20'h00042, "t3");
        show(2, 7'h7F, "t3_d2");
        show(3, 7'h7F, "t3_d3");
        show(4, 7'h7F, "t3_d4");
        show(0, 7'b0100100, "t3_d0");
        show(1, 7'b0011001, "t3_d1");

        convert(16'd0, 20'h00000, "t4a");
        show(0, 7'b1000000, "t4a_d0");
        show(1, 7'h7F, "t4a_d1");
        convert(16'd100, 20'h00100, "t4b");
        show(0, 7'b1000000, "t4b_d0");
        show(1, 7'b1000000, "t4b_d1");
        show(2, 7'b1111001, "t4b_d2");
        show(3, 7'h7F, "t4b_d3");

        // Second edge mid-conversion must be ignored and flagged.
        d_in      = 16'd1234;
        done_flag = 1'b1;
        tick();
        done_flag = 1'b0;
        repeat (3) tick();
        d_in      = 16'd999;
        done_flag = 1'b1;
        tick();
        chk("t5_ovr_set", {31'd0, overrun}, 32'd1);
        for (int i = 0; i < 40; i++) begin
            if (bcd_valid) break;
            tick();
        end
        chk("t5_valid", {31'd0, bcd_valid}, 32'd1);
        chk("t5_bcd", {12'd0, bcd_out}, 32'h01234);
        chk("t5_ovr_sticky", {31'd0, overrun}, 32'd1);
        done_flag = 1'b0;
        ovr_clr   = 1'b1;
        tick();
        ovr_clr = 1'b0;
        chk("t5_ovr_clr", {31'd0, overrun}, 32'd0);
        d_in      = 16'd5;
        done_flag = 1'b1;
        tick();
        done_flag = 1'b0;
        tick();
        done_flag = 1'b1;
        ovr_clr   = 1'b1;
        tick();
        ovr_clr = 1'b0;
        chk("t5_set_wins", {31'd0, overrun}, 32'd1);
        repeat (20) tick();
        chk("t5b_bcd", {12'd0, bcd_out}, 32'h00005);
        done_flag = 1'b0;
        ovr_clr   = 1'b1;
        tick();
        ovr_clr = 1'b0;

        // Held-high done_flag yields exactly one conversion.
        d_in      = 16'd777;
        done_flag = 1'b1;
        pulses    = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bcd_valid) pulses++;
        end
        chk("t6_pulses", pulses, 1);
        chk("t6_bcd", {12'd0, bcd_out}, 32'h00777);
        chk("t6_ovr", {31'd0, overrun}, 32'd0);

        // Asynchronous reset mid-conversion.
        done_flag = 1'b0;
        d_in      = 16'd65535;
        tick();
        done_flag = 1'b1;
        repeat (5) tick();
        chk("t1_busy_pre", {31'd0, busy}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("t1_busy", {31'd0, busy}, 32'd0);
        chk("t1_bcd", {12'd0, bcd_out}, 32'd0);
        chk("t1_an", {24'd0, seg_an}, 32'hFE);
        chk("t1_seg", {25'd0, seg_data}, 32'h40);
        done_flag = 1'b0;
        #2 rst = 1'b1;
        repeat (20) tick();
        chk("t1_abort", {12'd0, bcd_out}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
